mips_hazard_unit: RTL and testbench
===================================

# mips_hazard_unit

Parametrised hazard and forwarding controller for the pipelined MIPS core; it is the next generation of the fixed per-operand forwarding flags that the core top currently wires between control and datapath. It tracks destination registers through the EX, MEM and WB stages, generates registered forwarding selects for both ALU operands, and detects load-use hazards, stalling ID and injecting EX bubbles. It also squashes fetch on ID-resolved redirects and keeps a saturating stall counter. It sits beside `control`, taking decoded ID-stage fields and driving the datapath bypass muxes and PC/IF-ID enables.

## Interface
- `REG_AW`, 5: register-index width; index 0 is hard-wired zero.
- `LOAD_LAT`, 1: bubbles a load needs before its result is forwardable (1..3).
- `CNT_W`, 16: stall-counter width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: a real instruction is in ID.
- `id_rs`, `id_rt` in REG_AW: source indices.
- `id_use_rs`, `id_use_rt` in 1: the operand is actually read.
- `id_dst` in REG_AW: destination index (already RegDst-muxed).
- `id_reg_wr` in 1: the instruction writes `id_dst`.
- `id_is_load` in 1: LW.
- `id_redirect` in 1: taken branch/jump/jr resolved in ID.
- `fwd_a`, `fwd_b` out 2: EX operand selects. 0 regfile, 1 EX/MEM, 2 MEM/WB, 3 WB retire latch.
- `stall` out 1: hold PC and IF/ID.
- `ex_bubble` out 1: load a NOP into ID/EX.
- `flush_if` out 1: load a NOP into IF/ID.
- `redirect_ok` out 1: PC may take the redirect this cycle.
- `stall_cnt` out CNT_W: saturating count of stall cycles.

## Operation
- Scoreboard: one entry per stage EX, MEM, WB, plus a retire entry R. Each entry holds {valid, wr, dst, load, lcnt}. The scoreboard advances every cycle; stages never stall below ID.
- Entering EX: the ID fields if `id_valid` and not `ex_bubble`, else an invalid entry.
- Hit for source s against entry E: E.valid && E.wr && E.dst==s && s!=0 && use_s.
- Select priority, youngest first, evaluated in ID against entries as they will stand when the instruction is in EX:
  - EX hit -> 1.
  - MEM hit -> 2.
  - WB hit -> 3.
  - Otherwise 0.
- Load-use: `stall` is asserted if any used source hits an entry with load=1 whose remaining bubble count lcnt is nonzero. lcnt is loaded with LOAD_LAT on EX entry and decremented on each advance. With LOAD_LAT=1, only an EX-stage load stalls.
- `ex_bubble` = `stall` || (`flush` applied to the ID instruction per Configuration).
- Redirect: `redirect_ok` = `id_valid` && `id_redirect` && !`stall`. A redirect from a stalled instruction is deferred until the stall clears.
- `stall_cnt` increments each cycle `stall`=1 and saturates at all-ones.

## Timing
- Reset (`rst`=0, async):
  - All entries invalid.
  - `fwd_a` = `fwd_b` = 0.
  - `stall` = `ex_bubble` = `flush_if` = `redirect_ok` = 0.
  - `stall_cnt` = 0.
- Reset mid-stall clears everything immediately; there is no residual bubble after release.
- `fwd_a`/`fwd_b` are registered: computed in ID cycle N, valid for EX in cycle N+1. They are held at 0 when the EX entry is a bubble.
- `stall`, `ex_bubble`, `flush_if` and `redirect_ok` are combinational in the same cycle from ID inputs and registered state.
- Back-to-back loads to the same register: each load-use stalls independently. Sequences of LOAD_LAT stall cycles must not merge or skip.
- Stall and redirect in the same cycle: stall wins, `flush_if`=0.

## Configuration
- `MIPS_DELAY_SLOT_EN` defined: delay-slot semantics. On `redirect_ok`, the IF instruction (the slot) proceeds and `flush_if`=0.
- `MIPS_DELAY_SLOT_EN` undefined: `flush_if` = `redirect_ok`, so the fetched slot instruction becomes a NOP in IF/ID. The ID instruction still proceeds.

## Structure
- Package `mips_pkg`:
  - `fwd_sel_e` enum: FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WB.
  - `sb_entry_t` packed struct.
  - `REG_ZERO` constant.
- Sub-module `mips_fwd_cmp`: one instance per operand; takes a source index and use bit plus the three entries and returns `fwd_sel_e` and a load-hit flag.

## Test plan
- ADDI $2 then SUBU $3,$2,$4 back-to-back -> in the SUBU EX cycle, `fwd_a`=1 and `fwd_b`=0.
- LW $5 then NOR $6,$5,$7 with LOAD_LAT=1 -> exactly 1 cycle of `stall`=1 and `ex_bubble`=1, then `fwd_a`=2; `stall_cnt` 0->1.
- Producer to $0 followed by a consumer of $0 -> `fwd_a`=0 and no stall.
- Producer $8 with consumer $8 three instructions later -> `fwd_b`=3. Four instructions later -> 0.
- Load-use stall on a BLTZ whose `id_redirect`=1 -> `redirect_ok`=0 in the stall cycle and 1 in the next. `flush_if`=1 only without `MIPS_DELAY_SLOT_EN`.
- `rst` asserted low during a stall -> all outputs 0 asynchronously. After release, a consumer of the earlier load target gets `fwd`=0 and no stall.

Source files
------------

// File: rtl/mips_hazard_unit_pkg.sv
// mips_pkg: shared types for the MIPS hazard/forwarding unit.
//   fwd_sel_e  - EX operand bypass select (regfile, EX/MEM, MEM/WB, WB retire latch)
//   sb_entry_t - one scoreboard slot {valid, wr, dst, load, lcnt}
//   REG_ZERO   - the hard-wired zero register index
// Scoreboard dst fields are SB_DST_W wide, so REG_AW must not exceed SB_DST_W.
// lcnt is LCNT_W wide, enough for LOAD_LAT up to 3.
package mips_pkg;

  localparam int unsigned SB_DST_W = 8;
  localparam int unsigned LCNT_W   = 2;

  localparam logic [SB_DST_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_WB    = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic                wr;
    logic [SB_DST_W-1:0] dst;
    logic                load;
    logic [LCNT_W-1:0]   lcnt;
  } sb_entry_t;

  // One pipeline advance: the remaining load bubble count drops toward zero.
  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t o;
    o = e;
    if (e.lcnt != '0) o.lcnt = e.lcnt - LCNT_W'(1);
    return o;
  endfunction

endpackage

// File: rtl/mips_hazard_unit_if.sv
// mips_hazard_if: ID-stage fields in, bypass selects and pipeline controls out.
//   master : decode/datapath side (drives id_*, consumes controls)
//   slave  : hazard unit
//   id_*        decoded ID-stage instruction fields
//   fwd_a/fwd_b registered EX operand selects
//   stall, ex_bubble, flush_if, redirect_ok  same-cycle pipeline controls
//   stall_cnt   saturating stall-cycle count
//   sb_dbg      scoreboard contents {R, WB, MEM, EX}
// There is no valid/ready pair here: id_valid qualifies the id_* fields in the
// cycle they are presented, and stall=1 means the ID instruction was not
// accepted and must be presented again, unchanged, in the next cycle.
interface mips_hazard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) ();
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_wr;
  logic              id_is_load;
  logic              id_redirect;

  mips_pkg::fwd_sel_e        fwd_a;
  mips_pkg::fwd_sel_e        fwd_b;
  logic                      stall;
  logic                      ex_bubble;
  logic                      flush_if;
  logic                      redirect_ok;
  logic [CNT_W-1:0]          stall_cnt;
  mips_pkg::sb_entry_t [3:0] sb_dbg;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_wr,
           id_is_load, id_redirect,
    input  fwd_a, fwd_b, stall, ex_bubble, flush_if, redirect_ok, stall_cnt, sb_dbg
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_wr,
           id_is_load, id_redirect,
    output fwd_a, fwd_b, stall, ex_bubble, flush_if, redirect_ok, stall_cnt, sb_dbg
  );
endinterface

// File: rtl/mips_hazard_unit_fwd_cmp.sv
// mips_fwd_cmp: per-operand comparator against the EX, MEM and WB scoreboard
// entries. Picks the youngest matching producer and flags a hit on a load
// whose result is not yet forwardable.
//   src, use_src  : source register index and whether it is read
//   ex, mem, wb   : scoreboard entries as currently registered
//   sel           : bypass select the operand will need in its EX cycle
//   load_hit      : some hit entry is a load with bubbles still outstanding
module mips_fwd_cmp
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  sb_entry_t         ex,
  input  sb_entry_t         mem,
  input  sb_entry_t         wb,
  output fwd_sel_e          sel,
  output logic              load_hit
);
  logic [SB_DST_W-1:0] src_x;
  logic                src_live;
  logic                hit_ex, hit_mem, hit_wb;

  assign src_x    = SB_DST_W'(src);
  assign src_live = use_src && (src_x != REG_ZERO);

  assign hit_ex  = src_live && ex.valid  && ex.wr  && (ex.dst  == src_x);
  assign hit_mem = src_live && mem.valid && mem.wr && (mem.dst == src_x);
  assign hit_wb  = src_live && wb.valid  && wb.wr  && (wb.dst  == src_x);

  // Current EX becomes EX/MEM when this instruction reaches EX, so the
  // stage offset maps directly onto the select code.
  always_comb begin
    sel = FWD_RF;
    if (hit_ex)       sel = FWD_EXMEM;
    else if (hit_mem) sel = FWD_MEMWB;
    else if (hit_wb)  sel = FWD_WB;
  end

  assign load_hit = (hit_ex  && ex.load  && (ex.lcnt  != '0)) ||
                    (hit_mem && mem.load && (mem.lcnt != '0)) ||
                    (hit_wb  && wb.load  && (wb.lcnt  != '0));
endmodule

// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit: hazard and forwarding controller for the pipelined MIPS core.
// Tracks destinations through EX, MEM, WB and a retire slot, registers the
// EX operand bypass selects, stalls ID on load-use and squashes fetch on
// ID-resolved redirects.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   hz   : mips_hazard_if.slave (ID fields in, controls out)
// Parameters: REG_AW register index width, LOAD_LAT load bubbles (1..3),
// CNT_W stall counter width.
// Build option MIPS_DELAY_SLOT_EN: the fetched slot instruction survives a
// taken redirect (flush_if stays 0); otherwise flush_if follows redirect_ok.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  mips_hazard_if.slave hz
);
  sb_entry_t        sb_ex, sb_mem, sb_wb, sb_r, ex_next;
  fwd_sel_e         sel_a, sel_b, fwd_a_q, fwd_b_q;
  logic             load_hit_a, load_hit_b;
  logic             stall, redirect_ok;
  logic [CNT_W-1:0] stall_cnt_q;

  mips_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_a (
    .src      (hz.id_rs),
    .use_src  (hz.id_use_rs),
    .ex       (sb_ex),
    .mem      (sb_mem),
    .wb       (sb_wb),
    .sel      (sel_a),
    .load_hit (load_hit_a)
  );

  mips_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_b (
    .src      (hz.id_rt),
    .use_src  (hz.id_use_rt),
    .ex       (sb_ex),
    .mem      (sb_mem),
    .wb       (sb_wb),
    .sel      (sel_b),
    .load_hit (load_hit_b)
  );

  // Gated by rst so every control reads 0 while reset is held, whatever ID shows.
  assign stall       = rst && hz.id_valid && (load_hit_a || load_hit_b);
  assign redirect_ok = rst && hz.id_valid && hz.id_redirect && !stall;

  // The ID instruction always proceeds on a redirect, so only a stall
  // turns it into an EX bubble.
  assign hz.stall       = stall;
  assign hz.ex_bubble   = stall;
  assign hz.redirect_ok = redirect_ok;
`ifdef MIPS_DELAY_SLOT_EN
  assign hz.flush_if    = 1'b0;
`else
  assign hz.flush_if    = redirect_ok;
`endif

  always_comb begin
    ex_next = '0;
    if (hz.id_valid && !stall) begin
      ex_next.valid = 1'b1;
      ex_next.wr    = hz.id_reg_wr;
      ex_next.dst   = SB_DST_W'(hz.id_dst);
      ex_next.load  = hz.id_is_load;
      ex_next.lcnt  = hz.id_is_load ? LCNT_W'(LOAD_LAT) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_ex       <= '0;
      sb_mem      <= '0;
      sb_wb       <= '0;
      sb_r        <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      sb_ex   <= ex_next;
      sb_mem  <= sb_age(sb_ex);
      sb_wb   <= sb_age(sb_mem);
      sb_r    <= sb_age(sb_wb);
      // A bubble entering EX carries no operands, so its selects stay at regfile.
      fwd_a_q <= ex_next.valid ? sel_a : FWD_RF;
      fwd_b_q <= ex_next.valid ? sel_b : FWD_RF;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.fwd_a     = fwd_a_q;
  assign hz.fwd_b     = fwd_b_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.sb_dbg    = {sb_r, sb_wb, sb_mem, sb_ex};
endmodule

// File: tb/tb_mips_hazard_unit.sv
// Testbench for mips_hazard_unit. Reference model keeps the last three
// instructions that entered EX (youngest first) and derives forwarding and
// load-use stalls from each producer's distance ahead of the ID instruction.
module tb_mips_hazard_unit;
  import mips_pkg::*;

  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef MIPS_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_hazard_if #(.REG_AW(5), .CNT_W(CNT_W)) hz_if ();

  mips_hazard_unit #(.REG_AW(5), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if.slave)
  );

  // ---------------- model state ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       redir;
  } id_t;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic [4:0] dst;
    logic       ld;
  } ins_t;

  ins_t       hist[$];   // hist[0] is the instruction now in EX
  logic [3:0] exp_q[$];  // {fwd_a, fwd_b} expected after the next edge
  id_t        cur;
  id_t        nop;
  logic [1:0] exp_fa, exp_fb;
  int         m_cnt;
  int         n_tests, n_fail;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  function automatic id_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic [4:0] dst,
                             input logic wr, input logic ld, input logic redir);
    id_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.dst = dst; i.wr = wr; i.ld = ld; i.redir = redir;
    return i;
  endfunction

  task automatic set_id(input id_t i);
    cur                = i;
    hz_if.id_valid     = i.v;
    hz_if.id_rs        = i.rs;
    hz_if.id_rt        = i.rt;
    hz_if.id_use_rs    = i.urs;
    hz_if.id_use_rt    = i.urt;
    hz_if.id_dst       = i.dst;
    hz_if.id_reg_wr    = i.wr;
    hz_if.id_is_load   = i.ld;
    hz_if.id_redirect  = i.redir;
  endtask

  // ---------------- reference model ----------------
  function automatic bit hit(input ins_t e, input logic [4:0] s, input logic u);
    return e.v && e.wr && (e.dst == s) && (s != 5'd0) && u;
  endfunction

  // Producer d instructions ahead of ID supplies select d (1..3); farther is regfile.
  function automatic int m_fwd(input logic [4:0] s, input logic u);
    for (int d = 1; d <= 3; d++)
      if (d <= hist.size())
        if (hit(hist[d-1], s, u)) return d;
    return 0;
  endfunction

  // A load d ahead still needs bubbles while d <= LOAD_LAT.
  function automatic bit m_stall();
    if (!cur.v) return 1'b0;
    for (int d = 1; d <= 3; d++)
      if (d <= LOAD_LAT && d <= hist.size())
        if (hist[d-1].ld && (hit(hist[d-1], cur.rs, cur.urs) || hit(hist[d-1], cur.rt, cur.urt)))
          return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [CNT_W-1:0] m_cnt_exp();
    return (m_cnt > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(m_cnt);
  endfunction

  function automatic bit m_rok();
    return cur.v && cur.redir && !m_stall();
  endfunction

  // Advance model and DUT by one clock; leaves time at posedge + 1.
  task automatic tick();
    bit         st;
    ins_t       e;
    logic [1:0] fa, fb;
    st   = m_stall();
    e.v  = cur.v && !st;
    e.wr = cur.wr;
    e.dst = cur.dst;
    e.ld = cur.ld;
    fa = e.v ? 2'(m_fwd(cur.rs, cur.urs)) : 2'd0;
    fb = e.v ? 2'(m_fwd(cur.rt, cur.urt)) : 2'd0;
    if (st) m_cnt++;
    exp_q.push_back({fa, fb});
    hist.push_front(e);
    if (hist.size() > 3) void'(hist.pop_back());
    @(posedge clk);
    #1;
    {exp_fa, exp_fb} = exp_q.pop_front();
  endtask

  task automatic drain();
    repeat (4) begin
      set_id(nop);
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    set_id(mk(1, 5'd3, 5'd4, 1, 1, 5'd6, 1, 1, 1));
    #1;
    n_tests++; if (hz_if.redirect_ok !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_ok: got %b want 0", hz_if.redirect_ok); end
    n_tests++; if (hz_if.flush_if !== 1'b0) begin n_fail++; $display("FAIL reset_flush_if: got %b want 0", hz_if.flush_if); end
    n_tests++; if (hz_if.stall !== 1'b0 || hz_if.ex_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b/%b want 0/0", hz_if.stall, hz_if.ex_bubble); end
    @(posedge clk);
    #1;
    n_tests++; if (hz_if.fwd_a !== FWD_RF || hz_if.fwd_b !== FWD_RF) begin n_fail++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", hz_if.fwd_a, hz_if.fwd_b); end
    n_tests++; if (hz_if.stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", hz_if.stall_cnt); end
    set_id(nop);
    rst = 1'b1;
    hist.delete();
    m_cnt = 0;
  endtask

  task automatic test_load_use();
    drain();
    set_id(mk(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0));   // LW $5
    #1;
    tick();
    set_id(mk(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0));   // NOR $6,$5,$7
    #1;
    for (int k = 0; k < LOAD_LAT; k++) begin
      n_tests++; if (hz_if.stall !== 1'b1 || hz_if.ex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_stall[%0d]: got %b/%b want 1/1", k, hz_if.stall, hz_if.ex_bubble); end
      tick();
      n_tests++; if (hz_if.stall_cnt !== CNT_W'(k + 1)) begin n_fail++; $display("FAIL lu_cnt[%0d]: got %0d want %0d", k, hz_if.stall_cnt, k + 1); end
      n_tests++; if (hz_if.fwd_a !== FWD_RF) begin n_fail++; $display("FAIL lu_bubble_fwd[%0d]: got %0d want 0", k, hz_if.fwd_a); end
    end
    n_tests++; if (hz_if.stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", hz_if.stall); end
    tick();
    n_tests++; if (hz_if.fwd_a !== 2'((LOAD_LAT < 3) ? LOAD_LAT + 1 : 0) || hz_if.fwd_b !== FWD_RF) begin n_fail++; $display("FAIL lu_fwd: got %0d/%0d want %0d/0", hz_if.fwd_a, hz_if.fwd_b, (LOAD_LAT < 3) ? LOAD_LAT + 1 : 0); end
  endtask

  task automatic test_exmem_fwd();
    drain();
    set_id(mk(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 0, 0));   // ADDI $2
    #1;
    tick();
    set_id(mk(1, 5'd2, 5'd4, 1, 1, 5'd3, 1, 0, 0));   // SUBU $3,$2,$4
    #1;
    n_tests++; if (hz_if.stall !== 1'b0) begin n_fail++; $display("FAIL exmem_stall: got %b want 0", hz_if.stall); end
    tick();
    n_tests++; if (hz_if.fwd_a !== FWD_EXMEM || hz_if.fwd_b !== FWD_RF) begin n_fail++; $display("FAIL exmem_fwd: got %0d/%0d want 1/0", hz_if.fwd_a, hz_if.fwd_b); end
  endtask

  task automatic test_zero_reg();
    drain();
    set_id(mk(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0));   // LW $0
    #1;
    tick();
    set_id(mk(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 0));   // consumer of $0
    #1;
    n_tests++; if (hz_if.stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b want 0", hz_if.stall); end
    tick();
    n_tests++; if (hz_if.fwd_a !== FWD_RF || hz_if.fwd_b !== FWD_RF) begin n_fail++; $display("FAIL zero_fwd: got %0d/%0d want 0/0", hz_if.fwd_a, hz_if.fwd_b); end
  endtask

  task automatic test_distance();
    for (int gap = 1; gap <= 4; gap++) begin
      drain();
      set_id(mk(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 0));   // producer $8
      #1;
      tick();
      for (int j = 1; j < gap; j++) begin
        set_id(mk(1, 5'd1, 5'd2, 1, 1, 5'd8, 0, 0, 0)); // names $8 but does not write
        #1;
        tick();
      end
      set_id(mk(1, 5'd9, 5'd8, 1, 1, 5'd10, 1, 0, 0));  // consumer rt=$8
      #1;
      tick();
      n_tests++; if (hz_if.fwd_b !== 2'((gap <= 3) ? gap : 0) || hz_if.fwd_a !== FWD_RF) begin n_fail++; $display("FAIL dist_fwd[%0d]: got %0d/%0d want 0/%0d", gap, hz_if.fwd_a, hz_if.fwd_b, (gap <= 3) ? gap : 0); end
    end
  endtask

  task automatic test_redirect_stall();
    drain();
    set_id(mk(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0));   // LW $9
    #1;
    tick();
    set_id(mk(1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 1));   // BLTZ $9 taken
    #1;
    n_tests++; if (hz_if.stall !== 1'b1 || hz_if.redirect_ok !== 1'b0 || hz_if.flush_if !== 1'b0) begin n_fail++; $display("FAIL redir_stalled: got stall=%b ok=%b flush=%b want 1/0/0", hz_if.stall, hz_if.redirect_ok, hz_if.flush_if); end
    for (int k = 1; k < LOAD_LAT; k++) tick();
    tick();
    n_tests++; if (hz_if.stall !== 1'b0 || hz_if.redirect_ok !== 1'b1) begin n_fail++; $display("FAIL redir_release: got stall=%b ok=%b want 0/1", hz_if.stall, hz_if.redirect_ok); end
    n_tests++; if (hz_if.flush_if !== !DS) begin n_fail++; $display("FAIL redir_flush: got %b want %b", hz_if.flush_if, !DS); end
    tick();
  endtask

  task automatic run_until_accepted(input id_t i, output int n_stall);
    n_stall = 0;
    set_id(i);
    #1;
    while (hz_if.stall === 1'b1 && n_stall < 8) begin
      n_stall++;
      tick();
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2, s3;
    drain();
    run_until_accepted(mk(1, 5'd1, 5'd0, 1, 0, 5'd11, 1, 1, 0), s0);   // LW $11
    run_until_accepted(mk(1, 5'd11, 5'd3, 1, 1, 5'd12, 1, 0, 0), s1);  // ADD uses $11
    run_until_accepted(mk(1, 5'd11, 5'd0, 1, 0, 5'd11, 1, 1, 0), s2);  // LW $11,0($11)
    run_until_accepted(mk(1, 5'd11, 5'd11, 1, 1, 5'd13, 1, 0, 0), s3); // ADD uses $11
    n_tests++; if (s1 !== LOAD_LAT) begin n_fail++; $display("FAIL b2b_first: got %0d stalls want %0d", s1, LOAD_LAT); end
    n_tests++; if (s3 !== LOAD_LAT) begin n_fail++; $display("FAIL b2b_second: got %0d stalls want %0d", s3, LOAD_LAT); end
    n_tests++; if (s0 + s2 !== ((LOAD_LAT >= 2) ? LOAD_LAT - 1 : 0)) begin n_fail++; $display("FAIL b2b_load_stalls: got %0d want %0d", s0 + s2, (LOAD_LAT >= 2) ? LOAD_LAT - 1 : 0); end
    n_tests++; if (hz_if.stall_cnt !== m_cnt_exp()) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", hz_if.stall_cnt, m_cnt_exp()); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_id(mk(1, 5'd1, 5'd0, 1, 0, 5'd10, 1, 1, 0));  // LW $10
    #1;
    tick();
    set_id(mk(1, 5'd10, 5'd0, 1, 0, 5'd14, 1, 0, 1)); // consumer $10, also redirects
    #1;
    n_tests++; if (hz_if.stall !== 1'b1) begin n_fail++; $display("FAIL rms_pre: got %b want 1", hz_if.stall); end
    rst = 1'b0;
    #1;
    n_tests++; if (hz_if.stall !== 1'b0 || hz_if.ex_bubble !== 1'b0 || hz_if.redirect_ok !== 1'b0 || hz_if.flush_if !== 1'b0) begin n_fail++; $display("FAIL rms_ctrl: got %b%b%b%b want 0000", hz_if.stall, hz_if.ex_bubble, hz_if.redirect_ok, hz_if.flush_if); end
    n_tests++; if (hz_if.stall_cnt !== '0 || hz_if.fwd_a !== FWD_RF || hz_if.fwd_b !== FWD_RF) begin n_fail++; $display("FAIL rms_regs: got cnt=%0d fwd=%0d/%0d want 0/0/0", hz_if.stall_cnt, hz_if.fwd_a, hz_if.fwd_b); end
    #1;
    rst = 1'b1;
    hist.delete();
    m_cnt = 0;
    #1;
    n_tests++; if (hz_if.stall !== 1'b0 || hz_if.redirect_ok !== 1'b1) begin n_fail++; $display("FAIL rms_after: got stall=%b ok=%b want 0/1", hz_if.stall, hz_if.redirect_ok); end
    tick();
    n_tests++; if (hz_if.fwd_a !== FWD_RF || hz_if.stall_cnt !== '0) begin n_fail++; $display("FAIL rms_fwd: got fwd=%0d cnt=%0d want 0/0", hz_if.fwd_a, hz_if.stall_cnt); end
  endtask

  task automatic test_random();
    bit hold;
    bit e_st;
    id_t i;
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        i.v     = ($urandom_range(0, 9) != 0);
        i.rs    = 5'($urandom_range(0, 5));
        i.rt    = 5'($urandom_range(0, 5));
        i.urs   = 1'($urandom_range(0, 1));
        i.urt   = 1'($urandom_range(0, 1));
        i.dst   = 5'($urandom_range(0, 5));
        i.ld    = ($urandom_range(0, 2) == 0);
        i.wr    = i.ld || ($urandom_range(0, 3) != 0);
        i.redir = ($urandom_range(0, 7) == 0);
        set_id(i);
      end
      #1;
      e_st = m_stall();
      n_tests++; if (hz_if.stall !== e_st || hz_if.ex_bubble !== e_st) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b/%b want %b", c, hz_if.stall, hz_if.ex_bubble, e_st); end
      n_tests++; if (hz_if.redirect_ok !== m_rok() || hz_if.flush_if !== (m_rok() && !DS)) begin n_fail++; $display("FAIL rnd_redir[%0d]: got ok=%b flush=%b want %b/%b", c, hz_if.redirect_ok, hz_if.flush_if, m_rok(), m_rok() && !DS); end
      tick();
      n_tests++; if (hz_if.fwd_a !== exp_fa || hz_if.fwd_b !== exp_fb) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got %0d/%0d want %0d/%0d", c, hz_if.fwd_a, hz_if.fwd_b, exp_fa, exp_fb); end
      n_tests++; if (hz_if.stall_cnt !== m_cnt_exp()) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, hz_if.stall_cnt, m_cnt_exp()); end
      hold = e_st;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_cnt   = 0;
    exp_fa  = 2'd0;
    exp_fb  = 2'd0;
    nop     = '0;
    set_id(nop);
    test_reset();
    test_load_use();
    test_exmem_fwd();
    test_zero_reg();
    test_distance();
    test_redirect_stall();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
